// File: rtl/inv_round_datapath_if.sv
// Handshake and data bundle for inv_round_datapath.
// The master side is the upstream/downstream environment, and the slave side is the datapath.
interface inv_round_datapath_if;
    logic         i_valid;
    logic         o_ready;
    logic [0:127] i_data;
    logic [0:127] i_round_key;
    logic         i_last;
    logic         o_valid;
    logic         i_ready;
    logic [0:127] o_data;
    logic         o_busy;

    modport master (
        output i_valid, i_data, i_round_key, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_round_key, i_last, i_ready,
        output o_ready, o_valid, o_data, o_busy
    );
endinterface

// File: rtl/inv_round_datapath.sv
// AES inverse-round datapath: AddRoundKey after InvShiftRows, then InvMixColumns one column per falling edge.
// Define AES_INV_MIX_EN to build the InvMixColumns stage; without it, every state goes straight to DONE.
module inv_round_datapath (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    inv_round_datapath_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
`ifdef AES_INV_MIX_EN
    localparam logic [1:0] MIX  = 2'd1;
`endif
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [0:127] data_q, data_d;
    logic         ready_en_q, ready_en_d;
`ifdef AES_INV_MIX_EN
    logic [1:0]   cnt_q, cnt_d;
`endif

    // Output byte (r,c) takes input byte (r,(c-r) mod 4); byte k sits at row k%4, column k/4.
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

`ifdef AES_INV_MIX_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies by a 4-bit constant as a sum of b*1, b*2, b*4, b*8.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        logic [0:31] o;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        o[0:7]   = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
        o[8:15]  = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
        o[16:23] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
        o[24:31] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        return o;
    endfunction
`endif

    // ready_en holds o_ready low from reset assertion until the first falling edge after release.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ready_en_d = 1'b1;
`ifdef AES_INV_MIX_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_valid && ready_en_q) begin
                    data_d = inv_shift_rows(bus.i_data) ^ bus.i_round_key;
`ifdef AES_INV_MIX_EN
                    cnt_d   = 2'd0;
                    state_d = bus.i_last ? DONE : MIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef AES_INV_MIX_EN
            MIX: begin
                data_d[32*cnt_q +: 32] = inv_mix_col(data_q[32*cnt_q +: 32]);
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            ready_en_q <= 1'b0;
`ifdef AES_INV_MIX_EN
            cnt_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ready_en_q <= ready_en_d;
`ifdef AES_INV_MIX_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.o_ready = ready_en_q && (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_data  = data_q;

endmodule

// File: tb/tb_inv_round_datapath.sv
// Directed-vector bench for inv_round_datapath; expectations follow AES_INV_MIX_EN when it is defined.
module tb_inv_round_datapath;

    logic i_clock;
    logic i_reset_n;
    int   total;
    int   bad;

    inv_round_datapath_if bus ();

    inv_round_datapath dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    initial i_clock = 1'b1;
    always #5 i_clock = ~i_clock;

`ifdef AES_INV_MIX_EN
    localparam int           MIX_LAT   = 4;
    localparam logic [0:127] EXP_8E    = 128'hdb135345db135345db135345db135345;
    localparam logic [0:127] EXP_F2    = 128'h9fdc589d9fdc589d9fdc589d9fdc589d;
    localparam logic [0:127] EXP_MIXED = 128'hdb1353459fdc589d00000000ffffffff;
`else
    localparam int           MIX_LAT   = 0;
    localparam logic [0:127] EXP_8E    = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;
    localparam logic [0:127] EXP_F2    = 128'hf20a225cf20a225cf20a225cf20a225c;
    localparam logic [0:127] EXP_MIXED = 128'h8e4da1bcf20a225c00000000ffffffff;
`endif

    localparam logic [0:127] IN_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] IN_8E     = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;
    localparam logic [0:127] IN_F2     = 128'hf20a225cf20a225cf20a225cf20a225c;
    // Pre-rotated so that InvShiftRows yields columns 8e4da1bc, f20a225c, 00000000, ffffffff.
    localparam logic [0:127] IN_MIXED  = 128'h8e0a00fff200ffbc00ffa15cff4d2200;
    localparam logic [0:127] ALL_FF    = {128{1'b1}};
    localparam logic [0:127] EXP_SEQ   = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [0:127] EXP_SEQFF = 128'hfff2f5f8fbfef1f4f7fafdf0f3f6f9fc;

    task automatic tick();
        @(negedge i_clock);
        #1;
    endtask

    task automatic send_state(input logic [0:127] d, input logic [0:127] k, input logic l,
                              output logic [0:127] got, output int lat);
        int w;
        w = 0;
        while (!bus.o_ready && w < 20) begin
            tick();
            w++;
        end
        bus.i_data      = d;
        bus.i_round_key = k;
        bus.i_last      = l;
        bus.i_valid     = 1'b1;
        tick();
        bus.i_valid     = 1'b0;
        bus.i_data      = ~d;
        bus.i_round_key = ~k;
        bus.i_last      = ~l;
        lat = 0;
        while (!bus.o_valid && lat < 20) begin
            tick();
            lat++;
        end
        got = bus.o_data;
        if (!bus.o_valid) lat = -1;
    endtask

    task automatic release_output();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_data  = '0;
        bus.i_round_key = '0;
        #1;
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", bus.o_ready); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.o_valid); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.o_busy); end
        total++; if (bus.o_data !== 128'h0) begin bad++; $display("[TB] FAIL reset_data got=%h exp=0", bus.o_data); end
        tick();
        tick();
        i_reset_n = 1'b1;
        #1;
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_ready_early got=%b exp=0", bus.o_ready); end
        tick();
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%b exp=1", bus.o_ready); end
    endtask

    task automatic test_last_round();
        logic [0:127] vd[2], vk[2], ve[2], got;
        int lat;
        vd[0] = IN_SEQ; vk[0] = '0;     ve[0] = EXP_SEQ;
        vd[1] = IN_SEQ; vk[1] = ALL_FF; ve[1] = EXP_SEQFF;
        for (int i = 0; i < 2; i++) begin
            send_state(vd[i], vk[i], 1'b1, got, lat);
            total++; if (lat !== 0) begin bad++; $display("[TB] FAIL last_latency[%0d] got=%0d exp=0", i, lat); end
            total++; if (got !== ve[i]) begin bad++; $display("[TB] FAIL last_data[%0d] got=%h exp=%h", i, got, ve[i]); end
            release_output();
            total++; if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL last_ready[%0d] got=%b exp=1", i, bus.o_ready); end
        end
    endtask

    task automatic test_inv_mix();
        logic [0:127] vd[4], vk[4], ve[4], got;
        int lat;
        vd[0] = IN_8E;    vk[0] = '0;     ve[0] = EXP_8E;
        vd[1] = '0;       vk[1] = ALL_FF; ve[1] = ALL_FF;
        vd[2] = IN_F2;    vk[2] = '0;     ve[2] = EXP_F2;
        vd[3] = IN_MIXED; vk[3] = '0;     ve[3] = EXP_MIXED;
        for (int i = 0; i < 4; i++) begin
            send_state(vd[i], vk[i], 1'b0, got, lat);
            total++; if (lat !== MIX_LAT) begin bad++; $display("[TB] FAIL mix_latency[%0d] got=%0d exp=%0d", i, lat, MIX_LAT); end
            total++; if (got !== ve[i]) begin bad++; $display("[TB] FAIL mix_data[%0d] got=%h exp=%h", i, got, ve[i]); end
            total++; if (bus.o_busy !== 1'b1) begin bad++; $display("[TB] FAIL mix_busy[%0d] got=%b exp=1", i, bus.o_busy); end
            release_output();
        end
    endtask

    task automatic test_hold();
        logic [0:127] got;
        int lat;
        send_state(IN_SEQ, '0, 1'b1, got, lat);
        total++; if (got !== EXP_SEQ) begin bad++; $display("[TB] FAIL hold_first got=%h exp=%h", got, EXP_SEQ); end
        for (int i = 0; i < 3; i++) begin
            bus.i_valid     = 1'b1;
            bus.i_data      = {4{$urandom()}};
            bus.i_round_key = {4{$urandom()}};
            bus.i_last      = i[0];
            tick();
            total++; if (bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid[%0d] got=%b exp=1", i, bus.o_valid); end
            total++; if (bus.o_data !== EXP_SEQ) begin bad++; $display("[TB] FAIL hold_data[%0d] got=%h exp=%h", i, bus.o_data, EXP_SEQ); end
            total++; if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready[%0d] got=%b exp=0", i, bus.o_ready); end
        end
        bus.i_valid = 1'b0;
        release_output();
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_release_ready got=%b exp=1", bus.o_ready); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_release_valid got=%b exp=0", bus.o_valid); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("[TB] FAIL hold_release_busy got=%b exp=0", bus.o_busy); end
    endtask

    task automatic test_reset_mid_mix();
        logic [0:127] got;
        int lat;
        int late;
        bus.i_data      = IN_MIXED;
        bus.i_round_key = '0;
        bus.i_last      = 1'b0;
        bus.i_valid     = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b0;
        #1;
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid got=%b exp=0", bus.o_valid); end
        total++; if (bus.o_data !== 128'h0) begin bad++; $display("[TB] FAIL abort_data got=%h exp=0", bus.o_data); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b exp=0", bus.o_busy); end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL abort_ready got=%b exp=0", bus.o_ready); end
        tick();
        i_reset_n = 1'b1;
        late = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.o_valid) late++;
        end
        total++; if (late !== 0) begin bad++; $display("[TB] FAIL abort_late_valid got=%0d exp=0", late); end
        send_state(IN_8E, '0, 1'b0, got, lat);
        total++; if (got !== EXP_8E) begin bad++; $display("[TB] FAIL abort_next_data got=%h exp=%h", got, EXP_8E); end
        total++; if (lat !== MIX_LAT) begin bad++; $display("[TB] FAIL abort_next_latency got=%0d exp=%0d", lat, MIX_LAT); end
        release_output();
    endtask

    task automatic test_back_to_back();
        logic [0:127] vd[3], vk[3], ve[3], res[3];
        logic         vl[3];
        int           acc[3];
        int           j, nres, gap;
        logic         rdy;
        vd[0] = IN_MIXED; vk[0] = '0; vl[0] = 1'b0; ve[0] = EXP_MIXED;
        vd[1] = IN_SEQ;   vk[1] = '0; vl[1] = 1'b1; ve[1] = EXP_SEQ;
        vd[2] = IN_F2;    vk[2] = '0; vl[2] = 1'b0; ve[2] = EXP_F2;
        for (int i = 0; i < 3; i++) begin
            acc[i] = -1;
            res[i] = '0;
        end
        j = 0;
        nres = 0;
        bus.i_ready     = 1'b1;
        bus.i_data      = vd[0];
        bus.i_round_key = vk[0];
        bus.i_last      = vl[0];
        bus.i_valid     = 1'b1;
        for (int e = 0; e < 40; e++) begin
            rdy = bus.o_ready;
            tick();
            if (rdy && j < 3) begin
                acc[j] = e;
                j++;
                if (j < 3) begin
                    bus.i_data      = vd[j];
                    bus.i_round_key = vk[j];
                    bus.i_last      = vl[j];
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
            if (bus.o_valid) begin
                if (nres < 3) res[nres] = bus.o_data;
                nres++;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        total++; if (j !== 3) begin bad++; $display("[TB] FAIL b2b_accepts got=%0d exp=3", j); end
        total++; if (nres !== 3) begin bad++; $display("[TB] FAIL b2b_results got=%0d exp=3", nres); end
        for (int i = 0; i < 3; i++) begin
            total++; if (res[i] !== ve[i]) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, res[i], ve[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            gap = 2 + (vl[i] ? 0 : MIX_LAT);
            total++; if (acc[i+1] - acc[i] !== gap) begin bad++; $display("[TB] FAIL b2b_gap[%0d] got=%0d exp=%0d", i, acc[i+1] - acc[i], gap); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_last_round();
        test_inv_mix();
        test_hold();
        test_reset_mid_mix();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
